uart_rx_os: RTL and testbench

Parametrised, oversampling UART receiver. Successor to the existing single-tick receiver.
- Detects start bits on an oversample TICK from the baud generator and samples each bit at mid-bit.
- Supports configurable data bits, optional parity and 1/2 stop bits; reports framing, parity and overrun errors.
- Delivers bytes through a VALID/READY handshake to the downstream consumer (FIFO or processor I/O port).

---
 rtl/uart_rx_os.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_os.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with VALID/READY output register and frame error reporting.
// Optional build macro UART_RX_MAJORITY_VOTE_EN adds a line synchroniser and 2-of-3 sample voting.
module uart_rx_os #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 TICK,
  input  logic                 LINEIN,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 VALID,
  input  logic                 READY,
  output logic                 FRAME_ERR,
  output logic                 PARITY_ERR,
  output logic                 OVERRUN,
  output logic                 BUSY
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CMP_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CMP_FULL = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_HOLD
  } state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [BW-1:0]        bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 fe_reg, fe_next;
  logic                 pe_reg, pe_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 valid_reg, valid_next;
  logic                 ferr_reg, ferr_next;
  logic                 perr_reg, perr_next;
  logic                 ovr_reg, ovr_next;

  logic          line_s;
  logic          sample;
  logic [CW-1:0] cmp;
  logic          at_sample;
  logic          complete;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] sync_reg;
  logic [1:0] hist_reg;

  // History resets to idle-high so reset release cannot look like a start edge.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      sync_reg <= 2'b11;
      hist_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], LINEIN};
      if (TICK) hist_reg <= {hist_reg[0], line_s};
    end
  end

  assign line_s = sync_reg[1];
  assign sample = (hist_reg[1] & hist_reg[0]) | (hist_reg[1] & line_s) | (hist_reg[0] & line_s);
`else
  assign line_s = LINEIN;
  assign sample = LINEIN;
`endif

  assign cmp       = (state_reg == ST_START) ? CMP_HALF : CMP_FULL;
  assign at_sample = TICK && (cnt_reg == cmp);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      fe_reg    <= 1'b0;
      pe_reg    <= 1'b0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
      perr_reg  <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      fe_reg    <= fe_next;
      pe_reg    <= pe_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
      perr_reg  <= perr_next;
      ovr_reg   <= ovr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    fe_next    = fe_reg;
    pe_next    = pe_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    ferr_next  = ferr_reg;
    perr_next  = perr_reg;
    ovr_next   = ovr_reg;
    complete   = 1'b0;

    if (TICK && (state_reg inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}))
      cnt_next = at_sample ? '0 : cnt_reg + CW'(1);

    case (state_reg)
      ST_IDLE: begin
        if (TICK && !line_s) begin
          state_next = ST_START;
          cnt_next   = '0;
          fe_next    = 1'b0;
          pe_next    = 1'b0;
        end
      end
      ST_START: begin
        if (at_sample) begin
          state_next = sample ? ST_IDLE : ST_DATA;
          bit_next   = '0;
        end
      end
      ST_DATA: begin
        if (at_sample) begin
          shift_next = {sample, shift_reg[DATA_BITS-1:1]};
          if (bit_reg == BW'(DATA_BITS - 1)) begin
            bit_next   = '0;
            state_next = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_next = bit_reg + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (at_sample) begin
          pe_next    = ((^shift_reg) ^ sample) != (PARITY_MODE == 1);
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (at_sample) begin
          if (!sample) fe_next = 1'b1;
          // Leave at mid-stop so a back-to-back start edge is not missed.
          if (bit_reg == BW'(STOP_BITS - 1)) begin
            complete   = 1'b1;
            state_next = fe_next ? ST_HOLD : ST_IDLE;
          end else begin
            bit_next = bit_reg + BW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (TICK && line_s) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    if (complete && (!valid_reg || READY)) begin
      data_next  = shift_reg;
      ferr_next  = fe_next;
      perr_next  = pe_reg;
      valid_next = 1'b1;
      ovr_next   = 1'b0;
    end else if (complete) begin
      ovr_next = 1'b1;
    end else if (valid_reg && READY) begin
      valid_next = 1'b0;
      ovr_next   = 1'b0;
    end
  end

  assign DATA       = data_reg;
  assign VALID      = valid_reg;
  assign FRAME_ERR  = ferr_reg;
  assign PARITY_ERR = perr_reg;
  assign OVERRUN    = ovr_reg;
  assign BUSY       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: a default 8N1 receiver and a 7E2 receiver ticked every other clock,
// checked against a frame-level model of the output register.
module tb_uart_rx_os;

  logic CLOCK = 1'b0;
  logic RESET, tick_a, tick_b, line_a, line_b, ready_a, ready_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic valid_a, ferr_a, perr_a, ovr_a, busy_a;
  logic valid_b, ferr_b, perr_b, ovr_b, busy_b;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic       m_valid[2];
  logic [8:0] m_data[2];
  logic       m_fe[2];
  logic       m_pe[2];
  logic       m_ovr[2];

  localparam int CPB = 16;

  always #5 CLOCK = ~CLOCK;

  initial begin
    tick_b = 1'b0;
    forever @(negedge CLOCK) tick_b = ~tick_b;
  end

  initial begin
    #2000000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  uart_rx_os dut_a (
    .CLOCK(CLOCK), .RESET(RESET), .TICK(tick_a), .LINEIN(line_a),
    .DATA(data_a), .VALID(valid_a), .READY(ready_a),
    .FRAME_ERR(ferr_a), .PARITY_ERR(perr_a), .OVERRUN(ovr_a), .BUSY(busy_a)
  );

  uart_rx_os #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY_MODE(2), .STOP_BITS(2)) dut_b (
    .CLOCK(CLOCK), .RESET(RESET), .TICK(tick_b), .LINEIN(line_b),
    .DATA(data_b), .VALID(valid_b), .READY(ready_b),
    .FRAME_ERR(ferr_b), .PARITY_ERR(perr_b), .OVERRUN(ovr_b), .BUSY(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) line_a = v; else line_b = v;
  endtask

  task automatic set_ready(input int sel, input logic v);
    if (sel == 0) ready_a = v; else ready_b = v;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_valid[s] = 1'b0; m_data[s] = '0; m_fe[s] = 1'b0; m_pe[s] = 1'b0; m_ovr[s] = 1'b0;
    end
  endtask

  task automatic check_outs(input int sel, input string tag, input logic exp_busy);
    if (sel == 0) begin
      check({tag, ".data"},  32'(data_a),  32'(m_data[0]));
      check({tag, ".valid"}, 32'(valid_a), 32'(m_valid[0]));
      check({tag, ".ferr"},  32'(ferr_a),  32'(m_fe[0]));
      check({tag, ".perr"},  32'(perr_a),  32'(m_pe[0]));
      check({tag, ".ovr"},   32'(ovr_a),   32'(m_ovr[0]));
      check({tag, ".busy"},  32'(busy_a),  32'(exp_busy));
    end else begin
      check({tag, ".data"},  32'(data_b),  32'(m_data[1]));
      check({tag, ".valid"}, 32'(valid_b), 32'(m_valid[1]));
      check({tag, ".ferr"},  32'(ferr_b),  32'(m_fe[1]));
      check({tag, ".perr"},  32'(perr_b),  32'(m_pe[1]));
      check({tag, ".ovr"},   32'(ovr_b),   32'(m_ovr[1]));
      check({tag, ".busy"},  32'(busy_b),  32'(exp_busy));
    end
  endtask

  // Shifts a frame onto the line, one bit per CPB clocks; READY pulses for the clock after rdy_at.
  task automatic drive(input int sel, input logic [15:0] bits, input int nbits,
                       input int rdy_at, output int rise);
    logic v_prev, v_now;
    rise   = -1;
    v_prev = (sel == 0) ? valid_a : valid_b;
    set_line(sel, bits[0]);
    for (int c = 1; c <= nbits * CPB; c++) begin
      @(negedge CLOCK);
      v_now = (sel == 0) ? valid_a : valid_b;
      if (v_now && !v_prev && rise < 0) rise = c;
      v_prev = v_now;
      set_ready(sel, c == rdy_at);
      if ((c % CPB == 0) && (c < nbits * CPB)) set_line(sel, bits[c / CPB]);
    end
    set_line(sel, 1'b1);
    set_ready(sel, 1'b0);
  endtask

  task automatic settle_and_check(input int sel, input logic [8:0] d, input logic fe, input logic pe,
                                  input int rdy_at, input int last, input int rise, input string tag);
    logic was_valid;
    if (rdy_at >= 0 && rdy_at < last && m_valid[sel]) begin
      m_valid[sel] = 1'b0;
      m_ovr[sel]   = 1'b0;
    end
    was_valid = m_valid[sel];
    if (!was_valid || rdy_at == last) begin
      m_data[sel] = d; m_fe[sel] = fe; m_pe[sel] = pe; m_valid[sel] = 1'b1; m_ovr[sel] = 1'b0;
    end else begin
      m_ovr[sel] = 1'b1;
    end
    if (sel == 0 && !was_valid) check({tag, ".latency"}, rise, last + 1);
    repeat (2) @(negedge CLOCK);
    check_outs(sel, tag, 1'b0);
    $display("frame dut%0d %s data=0x%0h fe=%0b pe=%0b rdy_at=%0d", sel, tag, d, fe, pe, rdy_at);
  endtask

  // 8N1 frame; last stop sample is tick 8 + 16*9 = 152 with TICK every clock.
  task automatic frame_a(input logic [7:0] d, input logic stp, input int rdy_at, input int hold);
    int rise;
    logic [15:0] bits;
    bits = {6'b0, stp, d, 1'b0};
    drive(0, bits, 10, rdy_at, rise);
    if (hold > 0) begin
      line_a = 1'b0;
      repeat (hold) @(negedge CLOCK);
      check("hold.busy", 32'(busy_a), 32'd1);
      check("hold.ovr",  32'(ovr_a),  32'(m_ovr[0]));
      line_a = 1'b1;
    end
    settle_and_check(0, 9'(d), !stp, 1'b0, rdy_at, 152, rise, "a");
  endtask

  // 7E2 frame on the half-rate tick; parity error when data+parity hold an odd count of ones.
  task automatic frame_b(input logic [6:0] d, input logic par, input logic [1:0] stp, input int rdy_at);
    int rise;
    logic [15:0] bits;
    logic pe;
    bits = {5'b0, stp, par, d, 1'b0};
    pe   = ($countones({d, par}) % 2) != 0;
    drive(1, bits, 11, rdy_at, rise);
    settle_and_check(1, 9'(d), stp != 2'b11, pe, rdy_at, 168, rise, "b");
  endtask

  task automatic accept(input int sel);
    set_ready(sel, 1'b1);
    @(negedge CLOCK);
    set_ready(sel, 1'b0);
    if (m_valid[sel]) begin
      m_valid[sel] = 1'b0;
      m_ovr[sel]   = 1'b0;
    end
    check_outs(sel, "accept", 1'b0);
    $display("accept dut%0d", sel);
  endtask

  initial begin
    logic [8:0] tmp;
    int sel, r, rdy;
    logic [1:0] stp2;

    RESET = 1'b1; tick_a = 1'b1; line_a = 1'b1; line_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
    model_reset();
    repeat (3) @(negedge CLOCK);
    check_outs(0, "reset", 1'b0);
    check_outs(1, "resetb", 1'b0);
    RESET = 1'b0;
    @(negedge CLOCK);

    frame_a(8'hA5, 1'b1, -1, 0);

    // Short low pulse: start is rejected at the tick-8 mid-bit check.
    line_a = 1'b0;
    repeat (5) @(negedge CLOCK);
    line_a = 1'b1;
    check("false.busy5", 32'(busy_a), 32'd1);
    repeat (3) @(negedge CLOCK);
    check("false.busy8", 32'(busy_a), 32'd1);
    @(negedge CLOCK);
    check("false.busy9", 32'(busy_a), 32'd0);
    check_outs(0, "false", 1'b0);
    $display("false start rejected");

    frame_b(7'h37, 1'b0, 2'b11, -1);
    accept(1);
    frame_b(7'h07, 1'b1, 2'b11, -1);

    accept(0);
    frame_a(8'h00, 1'b0, -1, 200);

    accept(0);
    frame_a(8'h11, 1'b1, -1, 0);
    frame_a(8'h22, 1'b1, -1, 0);
    accept(0);
    frame_a(8'h33, 1'b1, 152, 0);

    // Reset in the middle of data bit 4.
    tmp = {8'hC3, 1'b0};
    for (int c = 0; c < 84; c++) begin
      line_a = tmp[c / CPB];
      @(negedge CLOCK);
    end
    check("rst.busy_pre", 32'(busy_a), 32'd1);
    RESET = 1'b1;
    line_a = 1'b1;
    @(negedge CLOCK);
    model_reset();
    check_outs(0, "rst", 1'b0);
    check_outs(1, "rstb", 1'b0);
    RESET = 1'b0;
    $display("reset mid-frame");
    repeat (3) @(negedge CLOCK);
    frame_a(8'h5A, 1'b1, -1, 0);

    for (int i = 0; i < 24; i++) begin
      sel = int'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 2));
      if (sel == 0) begin
        rdy = (r == 0) ? -1 : ((r == 1) ? 152 : 20);
        frame_a(8'($urandom_range(0, 255)), $urandom_range(0, 5) != 0, rdy, 0);
      end else begin
        rdy  = (r == 2) ? 20 : -1;
        stp2 = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
        frame_b(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), stp2, rdy);
      end
      if ($urandom_range(0, 2) == 0) accept(sel);
      repeat ($urandom_range(0, 5)) @(negedge CLOCK);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
